// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
// Shared widths and reset values for the TRNG collector slice.
//   WORD_BITS    : width of an output word
//   WIN_CNT_W    : width of the sampling-window counter
//   RUN_LEN_W    : width of the repetition-count run length
//   BIT_CNT_W    : width of the bits-in-word counter (must hold WORD_BITS)
//   *_RST        : reset values of the corresponding registers
// ---------------------------------------------------------------------------
package trng_pkg;

  localparam int WORD_BITS = 32;
  localparam int WIN_CNT_W = 16;
  localparam int RUN_LEN_W = 8;
  localparam int BIT_CNT_W = 6;

  localparam logic [WORD_BITS-1:0] DATA_RST     = '0;
  localparam logic [WIN_CNT_W-1:0] WIN_CNT_RST  = '0;
  localparam logic [RUN_LEN_W-1:0] RUN_LEN_RST  = '0;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_RST  = '0;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(WORD_BITS);

endpackage

// File: rtl/trng_rct.sv
// ---------------------------------------------------------------------------
// trng_rct
// Repetition count health test on the sampled window-bit stream.
//   clk, reset_n : clock, synchronous active-low reset
//   bit_valid    : a new window bit is present this cycle
//   bit_in       : the window bit ("bit" is a reserved word)
//   clear        : restart the run count
//   fail         : this bit brings the run length up to RCT_CUTOFF
//   run_len      : current run length (0 = no bit seen since reset/clear)
// ---------------------------------------------------------------------------
module trng_rct
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 clear,
  output logic                 fail,
  output logic [RUN_LEN_W-1:0] run_len
);

  localparam logic [RUN_LEN_W-1:0] CUTOFF = RUN_LEN_W'(RCT_CUTOFF);

  logic [RUN_LEN_W-1:0] runLen_q, runLen_d, runNext;
  logic                 prevBit_q, prevBit_d;

  // Run length including the incoming bit. A zero run length means no
  // previous bit exists yet, so the incoming bit always starts a new run.
  always_comb begin
    if (runLen_q == RUN_LEN_RST || bit_in != prevBit_q) begin
      runNext = RUN_LEN_W'(1);
    end else if (runLen_q >= CUTOFF) begin
      runNext = CUTOFF;
    end else begin
      runNext = runLen_q + RUN_LEN_W'(1);
    end
  end

  assign fail = bit_valid && (runNext == CUTOFF);

  // A failure in the same cycle as a clear keeps the saturated count so the
  // failing run is not silently forgotten.
  always_comb begin
    runLen_d  = runLen_q;
    prevBit_d = prevBit_q;
    if (bit_valid) begin
      runLen_d  = runNext;
      prevBit_d = bit_in;
    end
    if (clear && !fail) begin
      runLen_d = RUN_LEN_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      runLen_q  <= RUN_LEN_RST;
      prevBit_q <= 1'b0;
    end else begin
      runLen_q  <= runLen_d;
      prevBit_q <= prevBit_d;
    end
  end

  assign run_len = runLen_q;

endmodule

// File: rtl/trng_collector.sv
// ---------------------------------------------------------------------------
// trng_collector
// Consumer end of the ring-oscillator entropy sources: mixes NUM_SRC raw bits,
// folds SAMPLE_CYCLES cycles into one window bit, health-tests the window
// bits and packs them MSB-first into 32-bit words behind valid/ready.
//   clk, reset_n : clock, synchronous active-low reset
//   enable       : collection enable; low clears all partial collection state
//   entropy      : raw oscillator bits, already registered in clk domain
//   data         : current output word
//   data_valid   : data holds an unconsumed word
//   data_ready   : consumer accepts the word when data_valid is high
//   rct_error    : sticky repetition-count failure
//   clear_error  : single-cycle pulse clearing rct_error
// Optional feature macro: TRNG_VN_DEBIAS_EN (von Neumann debiasing of window
// bit pairs before they enter the shift register).
// ---------------------------------------------------------------------------
module trng_collector
  import trng_pkg::*;
#(
  parameter int NUM_SRC       = 16,
  parameter int SAMPLE_CYCLES = 16,
  parameter int RCT_CUTOFF    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_SRC-1:0]   entropy,
  output logic [WORD_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 rct_error,
  input  logic                 clear_error
);

  localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(SAMPLE_CYCLES - 1);

  logic [NUM_SRC-1:0]   entropy_q;
  logic                 mixBit;
  logic [WIN_CNT_W-1:0] winCnt_q, winCnt_d;
  logic                 acc_q, acc_d;
  logic                 winValid, winBit;
  logic                 rctBitValid, rctFail;
  logic [RUN_LEN_W-1:0] runLen_unused;
  logic                 shBitValid, shBit;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic                 dataValid_q, dataValid_d;
  logic                 rctError_q, rctError_d;
  logic                 transfer;

  assign mixBit = ^entropy_q;

  // Window folding: the last cycle of a window folds mixBit straight into
  // the emitted bit rather than waiting a cycle for the accumulator.
  always_comb begin
    winCnt_d = winCnt_q;
    acc_d    = acc_q;
    winValid = 1'b0;
    winBit   = acc_q ^ mixBit;
    if (!enable) begin
      winCnt_d = WIN_CNT_RST;
      acc_d    = 1'b0;
    end else if (winCnt_q == WIN_LAST) begin
      winValid = 1'b1;
      winCnt_d = WIN_CNT_RST;
      acc_d    = 1'b0;
    end else begin
      winCnt_d = winCnt_q + WIN_CNT_W'(1);
      acc_d    = acc_q ^ mixBit;
    end
  end

  // Window bits are ignored entirely while a health failure is pending.
  assign rctBitValid = winValid && !rctError_q;

  trng_rct #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (rctBitValid),
    .bit_in    (winBit),
    .clear     (clear_error),
    .fail      (rctFail),
    .run_len   (runLen_unused)
  );

`ifdef TRNG_VN_DEBIAS_EN
  localparam logic PAIR_FIRST  = 1'b0;
  localparam logic PAIR_SECOND = 1'b1;

  logic pairPhase_q, pairPhase_d;
  logic firstBit_q, firstBit_d;

  // Von Neumann pairing: 10 emits 1, 01 emits 0, equal pairs emit nothing.
  // The pair phase is not restarted by a word transfer, otherwise pairs
  // would be split depending on consumer timing.
  always_comb begin
    pairPhase_d = pairPhase_q;
    firstBit_d  = firstBit_q;
    shBitValid  = 1'b0;
    shBit       = firstBit_q;
    if (!enable || rctFail || clear_error) begin
      pairPhase_d = PAIR_FIRST;
    end else if (rctBitValid) begin
      if (pairPhase_q == PAIR_FIRST) begin
        firstBit_d  = winBit;
        pairPhase_d = PAIR_SECOND;
      end else begin
        shBitValid  = (firstBit_q != winBit);
        pairPhase_d = PAIR_FIRST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pairPhase_q <= PAIR_FIRST;
      firstBit_q  <= 1'b0;
    end else begin
      pairPhase_q <= pairPhase_d;
      firstBit_q  <= firstBit_d;
    end
  end
`else
  assign shBitValid = rctBitValid;
  assign shBit      = winBit;
`endif

  assign transfer = (bitCnt_q == BIT_CNT_FULL) && (!dataValid_q || data_ready);

  // Word assembly and handshake. A transfer captures the pre-shift register
  // so a bit arriving in the same cycle becomes bit 1 of the next word. When
  // the buffer is full and blocked, bits keep shifting so the next word is
  // always the most recent 32 bits. A health failure overrides everything.
  always_comb begin
    shreg_d     = shreg_q;
    bitCnt_d    = bitCnt_q;
    data_d      = data_q;
    dataValid_d = dataValid_q;
    rctError_d  = rctError_q;
    if (dataValid_q && data_ready) begin
      dataValid_d = 1'b0;
    end
    if (!enable) begin
      shreg_d  = DATA_RST;
      bitCnt_d = BIT_CNT_RST;
    end else begin
      if (shBitValid) begin
        shreg_d = {shreg_q[WORD_BITS-2:0], shBit};
      end
      if (transfer) begin
        data_d      = shreg_q;
        dataValid_d = 1'b1;
        bitCnt_d    = {{(BIT_CNT_W-1){1'b0}}, shBitValid};
      end else if (shBitValid && bitCnt_q != BIT_CNT_FULL) begin
        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
      end
    end
    if (clear_error) begin
      rctError_d = 1'b0;
      bitCnt_d   = BIT_CNT_RST;
    end
    if (rctFail) begin
      rctError_d  = 1'b1;
      dataValid_d = 1'b0;
      data_d      = data_q;
      bitCnt_d    = BIT_CNT_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entropy_q   <= '0;
      winCnt_q    <= WIN_CNT_RST;
      acc_q       <= 1'b0;
      shreg_q     <= DATA_RST;
      bitCnt_q    <= BIT_CNT_RST;
      data_q      <= DATA_RST;
      dataValid_q <= 1'b0;
      rctError_q  <= 1'b0;
    end else begin
      entropy_q   <= entropy;
      winCnt_q    <= winCnt_d;
      acc_q       <= acc_d;
      shreg_q     <= shreg_d;
      bitCnt_q    <= bitCnt_d;
      data_q      <= data_d;
      dataValid_q <= dataValid_d;
      rctError_q  <= rctError_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dataValid_q;
  assign rct_error  = rctError_q;

endmodule

// File: tb/tb_trng_collector.sv
// ---------------------------------------------------------------------------
// tb_trng_collector
// Directed bench for trng_collector (NUM_SRC=4, SAMPLE_CYCLES=4). Each window
// bit is produced by one odd/even-parity entropy vector per 4-cycle group,
// surrounded by even-parity vectors. Expected words are queued before the
// bits are driven; a monitor pops and compares on every accepted word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trng_collector;

  localparam int NUM_SRC       = 4;
  localparam int SAMPLE_CYCLES = 4;
  localparam int RCT_CUTOFF    = 32;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic [NUM_SRC-1:0] entropy = '0;
  logic               data_ready = 1'b0;
  logic               clear_error = 1'b0;
  logic [31:0]        data;
  logic               data_valid;
  logic               rct_error;

  int          total = 0;
  int          bad = 0;
  logic [31:0] expQ[$];
  logic [31:0] expWord;

  trng_collector #(
    .NUM_SRC       (NUM_SRC),
    .SAMPLE_CYCLES (SAMPLE_CYCLES),
    .RCT_CUTOFF    (RCT_CUTOFF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .entropy     (entropy),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .rct_error   (rct_error),
    .clear_error (clear_error)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every accepted word is compared with the head of the queue.
  always begin
    @(negedge clk);
    #2;
    if (reset_n && data_valid && data_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedWord: got 0x%08h, want no word", data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("word", data, expWord);
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [NUM_SRC-1:0] ent);
    @(negedge clk);
    enable  = en;
    entropy = ent;
  endtask

  // One window: only the second vector carries odd parity for a 1.
  task automatic driveBit(input logic b);
    applyStimulus(1'b1, 4'b0101);
    applyStimulus(1'b1, b ? 4'b1011 : 4'b1001);
    applyStimulus(1'b1, 4'b1111);
    applyStimulus(1'b1, 4'b0000);
  endtask

  task automatic driveWord(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) begin
      driveBit(w[i]);
    end
  endtask

  // Two more enabled cycles let a just-completed word transfer, then disable.
  task automatic finishRun();
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    repeat (4) applyStimulus(1'b0, 4'b0000);
  endtask

  initial begin
    // Reset and idle with enable low
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("resetData", data, 32'h0);
    checkOutput("resetValid", {31'b0, data_valid}, 32'd0);
    checkOutput("resetRct", {31'b0, rct_error}, 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    data_ready = 1'b1;
    repeat (200) applyStimulus(1'b0, NUM_SRC'($urandom_range(0, 15)));
    repeat (2) applyStimulus(1'b0, 4'b0000);
    #2;
    checkOutput("idleValid", {31'b0, data_valid}, 32'd0);

`ifdef TRNG_VN_DEBIAS_EN
    // Pairs 10,01,11,00 emit 1,0 per group of four pairs
    expQ.push_back(32'hAAAAAAAA);
    repeat (16) begin
      driveBit(1'b1); driveBit(1'b0);
      driveBit(1'b0); driveBit(1'b1);
      driveBit(1'b1); driveBit(1'b1);
      driveBit(1'b0); driveBit(1'b0);
    end
    finishRun();
    #2;
    checkOutput("vnRct", {31'b0, rct_error}, 32'd0);
`else
    // Alternating bits, two back-to-back words
    expQ.push_back(32'hAAAAAAAA);
    expQ.push_back(32'hAAAAAAAA);
    driveWord(32'hAAAAAAAA);
    driveWord(32'hAAAAAAAA);
    finishRun();
    #2;
    checkOutput("consumedValid", {31'b0, data_valid}, 32'd0);

    // Backpressure: first word held while three more words stream past
    data_ready = 1'b0;
    expQ.push_back(32'hAAAAAAAA);
    expQ.push_back(32'h12345678);
    driveWord(32'hAAAAAAAA);
    driveWord(32'hC3C3C3C3);
    #2;
    checkOutput("bpValid", {31'b0, data_valid}, 32'd1);
    checkOutput("bpData", data, 32'hAAAAAAAA);
    driveWord(32'h0F0F0F0F);
    driveWord(32'h12345678);
    #2;
    checkOutput("bpDataHeld", data, 32'hAAAAAAAA);
    @(negedge clk);
    enable = 1'b1; entropy = 4'b0000; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    #2;
    checkOutput("reloadValid", {31'b0, data_valid}, 32'd1);
    checkOutput("reloadData", data, 32'h12345678);
    repeat (4) applyStimulus(1'b0, 4'b0000);
    #2;
    checkOutput("pendingWhileDisabled", {31'b0, data_valid}, 32'd1);
    @(negedge clk);
    data_ready = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("drainedValid", {31'b0, data_valid}, 32'd0);

    // Repetition count failure: 32 ones after a trailing 0
    driveWord(32'hFFFFFFFF);
    finishRun();
    #2;
    checkOutput("rctSet", {31'b0, rct_error}, 32'd1);
    checkOutput("rctValid", {31'b0, data_valid}, 32'd0);
    driveWord(32'hAAAAAAAA);
    finishRun();
    #2;
    checkOutput("rctSticky", {31'b0, rct_error}, 32'd1);
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    #2;
    checkOutput("rctCleared", {31'b0, rct_error}, 32'd0);
    expQ.push_back(32'h5A5AC3C3);
    driveWord(32'h5A5AC3C3);
    finishRun();

    // Enable dropped after 10 bits discards them
    repeat (10) driveBit(1'b1);
    finishRun();
    expQ.push_back(32'h13579BDF);
    driveWord(32'h13579BDF);
    finishRun();
    #2;
    checkOutput("finalRct", {31'b0, rct_error}, 32'd0);
`endif

    repeat (10) @(negedge clk);
    #2;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
